// File: rtl/axi_rd_req_arb.sv
// Round-robin arbiter folding NUM_REQ read requesters onto one registered axi_mst_rd request slot (AXI_RD_ARB_STARVE_EN adds starvation promotion).
// Latency: one cycle from req_valid to user_req_valid; back-to-back grants sustain one request per cycle.
// Backpressure: the held request stays stable until user_req_ready; req_ready only fires while the slot is empty or draining.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_rd_req_arb #(
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arb_en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*`AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*`AXI_LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*`AXI_SIZE_WIDTH-1:0]   req_size,
  input  logic [NUM_REQ*`AXI_BURST_WIDTH-1:0]  req_burst,
  output logic                                 user_req_valid,
  input  logic                                 user_req_ready,
  output logic [`AXI_ID_WIDTH-1:0]             user_req_id,
  output logic [`AXI_ADDR_WIDTH-1:0]           user_req_addr,
  output logic [`AXI_LEN_WIDTH-1:0]            user_req_len,
  output logic [`AXI_SIZE_WIDTH-1:0]           user_req_size,
  output logic [`AXI_BURST_WIDTH-1:0]          user_req_burst,
  output logic [$clog2(NUM_REQ)-1:0]           grant_idx
);

  localparam int AW    = `AXI_ADDR_WIDTH;
  localparam int LW    = `AXI_LEN_WIDTH;
  localparam int SW    = `AXI_SIZE_WIDTH;
  localparam int BW    = `AXI_BURST_WIDTH;
  localparam int ID_W  = `AXI_ID_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > (1 << ID_W)) begin : g_bad_num_req
    $error("axi_rd_req_arb: NUM_REQ out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("axi_rd_req_arb: STARVE_LIMIT out of range");
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [SW-1:0] size;
    logic [BW-1:0] burst;
  } payload_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  payload_t           slot_q;
  logic [IDX_W-1:0]   rr_ptr;
  payload_t           req_pl [NUM_REQ];
  logic [IDX_W-1:0]   win_idx;
  logic               handshake;
  logic               capture;

`ifdef AXI_RD_ARB_STARVE_EN
  logic [7:0]         wait_cnt [NUM_REQ];
`endif

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_pl[k] = '{addr:  req_addr[k*AW +: AW],
                    len:   req_len[k*LW +: LW],
                    size:  req_size[k*SW +: SW],
                    burst: req_burst[k*BW +: BW]};
    end
  end

  // Upward search from rr_ptr; a starving requester (lowest index first) overrides it.
  always_comb begin
    int   cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    win_idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[IDX_W'(cand)]) begin
        win_idx = IDX_W'(cand);
        found   = 1'b1;
      end
    end
`ifdef AXI_RD_ARB_STARVE_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[IDX_W'(k)] && (wait_cnt[k] == 8'(STARVE_LIMIT))) begin
        win_idx = IDX_W'(k);
      end
    end
`endif
  end

  assign handshake = user_req_valid & user_req_ready;
  assign capture   = rst_n & arb_en & (|req_valid) & ((state_q == IDLE) | handshake);

  always_comb begin
    req_ready = '0;
    if (capture) req_ready[win_idx] = 1'b1;
  end

  assign user_req_addr  = slot_q.addr;
  assign user_req_len   = slot_q.len;
  assign user_req_size  = slot_q.size;
  assign user_req_burst = slot_q.burst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      user_req_valid <= 1'b0;
      slot_q         <= '0;
      user_req_id    <= '0;
      grant_idx      <= '0;
      rr_ptr         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q        <= HOLD;
            user_req_valid <= 1'b1;
            slot_q         <= req_pl[win_idx];
            user_req_id    <= ID_W'(win_idx);
            grant_idx      <= win_idx;
            rr_ptr         <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        HOLD: begin
          // A draining slot refills in the same cycle to keep full throughput.
          if (capture) begin
            user_req_valid <= 1'b1;
            slot_q         <= req_pl[win_idx];
            user_req_id    <= ID_W'(win_idx);
            grant_idx      <= win_idx;
            rr_ptr         <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end else if (handshake) begin
            state_q        <= IDLE;
            user_req_valid <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          user_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_RD_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) wait_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_valid[IDX_W'(k)] || (capture && (win_idx == IDX_W'(k)))) begin
          wait_cnt[k] <= '0;
        end else if (wait_cnt[k] != 8'(STARVE_LIMIT)) begin
          wait_cnt[k] <= wait_cnt[k] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_req_arb.sv
// Bench for axi_rd_req_arb: directed vectors, literal expectations and a per-cycle reference model.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module tb_axi_rd_req_arb;
  localparam int N   = 4;
  localparam int LIM = 3;
  localparam int AW  = `AXI_ADDR_WIDTH;
  localparam int LW  = `AXI_LEN_WIDTH;
  localparam int SW  = `AXI_SIZE_WIDTH;
  localparam int BW  = `AXI_BURST_WIDTH;
  localparam int IW  = `AXI_ID_WIDTH;

  logic              clk;
  logic              rst_n;
  logic              arb_en;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*SW-1:0]   req_size;
  logic [N*BW-1:0]   req_burst;
  logic              user_req_valid;
  logic              user_req_ready;
  logic [IW-1:0]     user_req_id;
  logic [AW-1:0]     user_req_addr;
  logic [LW-1:0]     user_req_len;
  logic [SW-1:0]     user_req_size;
  logic [BW-1:0]     user_req_burst;
  logic [1:0]        grant_idx;

  logic [AW-1:0] addr_a  [N];
  logic [LW-1:0] len_a   [N];
  logic [SW-1:0] size_a  [N];
  logic [BW-1:0] burst_a [N];

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_req_arb #(.NUM_REQ(N), .STARVE_LIMIT(LIM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_en         (arb_en),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_size       (req_size),
    .req_burst      (req_burst),
    .user_req_valid (user_req_valid),
    .user_req_ready (user_req_ready),
    .user_req_id    (user_req_id),
    .user_req_addr  (user_req_addr),
    .user_req_len   (user_req_len),
    .user_req_size  (user_req_size),
    .user_req_burst (user_req_burst),
    .grant_idx      (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    req_burst = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = addr_a[k];
      req_len[k*LW +: LW]   = len_a[k];
      req_size[k*SW +: SW]  = size_a[k];
      req_burst[k*BW +: BW] = burst_a[k];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, round-robin pointer and wait counts as plain integers.
  bit             model_on = 1'b0;
  bit             m_valid  = 1'b0;
  int             m_ptr    = 0;
  int             m_id     = 0;
  int             waits [N];
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_len;
  logic [SW-1:0]  m_size;
  logic [BW-1:0]  m_burst;

  function automatic int pick();
`ifdef AXI_RD_ARB_STARVE_EN
    for (int k = 0; k < N; k++)
      if (req_valid[k] && waits[k] >= LIM) return k;
`endif
    for (int i = 0; i < N; i++)
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int           w;
    bit           cap;
    logic [N-1:0] exp_rdy;
    w       = pick();
    cap     = rst_n && arb_en && (w >= 0) && (!m_valid || user_req_ready);
    exp_rdy = cap ? (N'(1) << w) : '0;
    if (model_on) begin
      chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("m_user_req_valid", 64'(user_req_valid), 64'(m_valid));
      if (m_valid) begin
        chk("m_id", 64'(user_req_id), 64'(m_id));
        chk("m_grant_idx", 64'(grant_idx), 64'(m_id));
        chk("m_addr", 64'(user_req_addr), 64'(m_addr));
        chk("m_len", 64'(user_req_len), 64'(m_len));
        chk("m_size", 64'(user_req_size), 64'(m_size));
        chk("m_burst", 64'(user_req_burst), 64'(m_burst));
      end
    end
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_ptr    = 0;
      for (int k = 0; k < N; k++) waits[k] = 0;
      model_on = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || (cap && w == k)) waits[k] = 0;
        else if (waits[k] < LIM) waits[k]++;
      end
      if (cap) begin
        m_valid = 1'b1;
        m_id    = w;
        m_addr  = addr_a[w];
        m_len   = len_a[w];
        m_size  = size_a[w];
        m_burst = burst_a[w];
        m_ptr   = (w + 1) % N;
      end else if (m_valid && user_req_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {arb_en, user_req_ready, req_valid[3:0]}
  logic [5:0] tbl [12] = '{6'b11_0110, 6'b10_0110, 6'b10_1111, 6'b11_1111,
                           6'b01_1010, 6'b11_1010, 6'b11_0000, 6'b10_0001,
                           6'b11_0101, 6'b11_0101, 6'b01_0000, 6'b11_1000};
  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < N; k++) begin
      addr_a[k]  = AW'(32'h100 * (k + 1));
      len_a[k]   = LW'(k * 3 + 1);
      size_a[k]  = SW'(k + 1);
      burst_a[k] = BW'(k);
    end
    rst_n = 1'b0; arb_en = 1'b1; req_valid = '0; user_req_ready = 1'b0;
    tick(); tick();

    // Reset values; req_ready must stay low while reset is held.
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(user_req_valid), 64'h0);
    chk("rst_grant", 64'(grant_idx), 64'h0);
    chk("rst_addr", 64'(user_req_addr), 64'h0);
    chk("rst_id", 64'(user_req_id), 64'h0);
    req_valid = '0; rst_n = 1'b1; user_req_ready = 1'b1;
    tick();

    // Single request, one-cycle latency.
    req_valid = 4'b0001;
    #1;
    chk("single_rdy", 64'(req_ready), 64'h1);
    tick();
    chk("single_valid", 64'(user_req_valid), 64'h1);
    chk("single_addr", 64'(user_req_addr), 64'h100);
    chk("single_id", 64'(user_req_id), 64'h0);
    chk("single_grant", 64'(grant_idx), 64'h0);
    req_valid = '0;
    tick();
    chk("single_drain", 64'(user_req_valid), 64'h0);

    // Reset in the middle of a held request.
    req_valid = 4'b0100; user_req_ready = 1'b0;
    tick();
    chk("hold2_valid", 64'(user_req_valid), 64'h1);
    rst_n = 1'b0; req_valid = '0;
    tick();
    chk("midrst_valid", 64'(user_req_valid), 64'h0);
    chk("midrst_addr", 64'(user_req_addr), 64'h0);
    rst_n = 1'b1;

    // All requesting with ready high: 0,1,2,3,0 one per cycle.
    req_valid = 4'b1111; user_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_rdy", 64'(req_ready), 64'(4'b0001 << exp_g[i]));
      tick();
      chk("rr_grant", 64'(grant_idx), 64'(exp_g[i]));
      chk("rr_valid", 64'(user_req_valid), 64'h1);
    end
    req_valid = '0;
    tick();

    // Requester 2 stalled five cycles: payload stable, no req_ready.
    user_req_ready = 1'b0; req_valid = 4'b0100;
    #1;
    chk("stall_rdy0", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rdy", 64'(req_ready), 64'h0);
      chk("stall_addr", 64'(user_req_addr), 64'h300);
      chk("stall_grant", 64'(grant_idx), 64'h2);
      tick();
    end
    user_req_ready = 1'b1; req_valid = '0;
    #1;
    chk("stall_still_valid", 64'(user_req_valid), 64'h1);
    tick();
    chk("stall_done", 64'(user_req_valid), 64'h0);

    // Pointer at 3, requesters 3 and 0: 3 then wrap to 0.
    req_valid = 4'b1001;
    #1;
    chk("wrap_rdy3", 64'(req_ready), 64'h8);
    tick();
    chk("wrap_grant3", 64'(grant_idx), 64'h3);
    #1;
    chk("wrap_rdy0", 64'(req_ready), 64'h1);
    tick();
    chk("wrap_grant0", 64'(grant_idx), 64'h0);
    req_valid = '0;
    tick();

    // arb_en low: held request still completes, nothing new captured.
    req_valid = 4'b0010; user_req_ready = 1'b0;
    tick();
    arb_en = 1'b0; user_req_ready = 1'b1; req_valid = 4'b1111;
    #1;
    chk("dis_rdy", 64'(req_ready), 64'h0);
    tick();
    chk("dis_drain", 64'(user_req_valid), 64'h0);
    tick();
    chk("dis_idle", 64'(user_req_valid), 64'h0);
    arb_en = 1'b1; req_valid = '0;
    tick();

    // Requester 1 waits behind a stalled grant to 3; then 0 joins.
    req_valid = 4'b1010; user_req_ready = 1'b0;
    tick();
    chk("starve_hold3", 64'(grant_idx), 64'h3);
    for (int i = 0; i < 4; i++) tick();
    user_req_ready = 1'b1; req_valid = 4'b1011;
    #1;
`ifdef AXI_RD_ARB_STARVE_EN
    chk("starve_rdy", 64'(req_ready), 64'h2);
    tick();
    chk("starve_grant", 64'(grant_idx), 64'h1);
`else
    chk("starve_rdy", 64'(req_ready), 64'h1);
    tick();
    chk("starve_grant", 64'(grant_idx), 64'h0);
`endif
    req_valid = '0;
    tick();

    // Mixed directed vectors, checked by the model only.
    for (int i = 0; i < 12; i++) begin
      {arb_en, user_req_ready, req_valid} = tbl[i];
      tick();
    end
    arb_en = 1'b1; user_req_ready = 1'b1; req_valid = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_rd_req_arb.md
AXI_RD_REQ_ARB -- requirements
Module: axi_rd_req_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of user requesters sharing one axi_mst_rd request port; legal range 2..2^`AXI_ID_WIDTH.
REQ-002 Parameter STARVE_LIMIT, default 15: wait-cycle threshold for starvation promotion; legal range 1..255.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 arb_en  input  1  arbitration enable; low blocks new captures.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 req_addr  input  NUM_REQ*`AXI_ADDR_WIDTH  packed addresses; requester k occupies slice k.
REQ-009 req_len  input  NUM_REQ*`AXI_LEN_WIDTH  packed burst lengths.
REQ-010 req_size  input  NUM_REQ*`AXI_SIZE_WIDTH  packed burst sizes.
REQ-011 req_burst  input  NUM_REQ*`AXI_BURST_WIDTH  packed burst types.
REQ-012 user_req_valid  output  1  request valid to axi_mst_rd.
REQ-013 user_req_ready  input  1  request ready from axi_mst_rd.
REQ-014 user_req_id  output  `AXI_ID_WIDTH  winning requester index, zero-extended.
REQ-015 user_req_addr, user_req_len, user_req_size, user_req_burst  output  AXI widths  registered payload of the winner.
REQ-016 grant_idx  output  $clog2(NUM_REQ)  index of the held winner; valid while user_req_valid=1.

Function
REQ-017 The block SHALL implement two states: IDLE (output register empty) and HOLD (output register full, user_req_valid=1).
REQ-018 Capture condition: arb_en=1, |req_valid=1, and (state=IDLE or, in HOLD, user_req_valid&user_req_ready=1).
REQ-019 On capture, req_ready[w]=1 combinationally for winner w only; payload and index w are registered; state=HOLD from the next cycle.
REQ-020 Latency: request valid in cycle N in IDLE -> user_req_valid=1 in cycle N+1.
REQ-021 HOLD with handshake and no capture -> IDLE; HOLD with handshake and capture -> stays HOLD with the new payload; HOLD without handshake -> outputs held stable, req_ready=0.
REQ-022 Sustained throughput SHALL be one request per cycle while user_req_ready=1.
REQ-023 Round-robin: the winner is the first asserted req_valid searching upward from rr_ptr, modulo NUM_REQ; on capture rr_ptr <= (w+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
REQ-024 arb_en=0 SHALL NOT abort a held request; it completes normally and no capture occurs.
REQ-025 user_req_valid SHALL NOT deassert before handshake (AXI valid rule).
REQ-026 A requester dropping req_valid without req_ready SHALL be permitted and is simply not granted.

Reset
REQ-027 On rst_n=0 at a rising edge: state=IDLE, user_req_valid=0, all payload outputs and grant_idx=0, rr_ptr=0, starvation counters=0.
REQ-028 Reset asserted mid-HOLD SHALL discard the held request without a handshake.
REQ-029 req_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 Macro AXI_RD_ARB_STARVE_EN defined: each requester has an 8-bit wait counter, incremented per cycle with req_valid=1 and not granted, saturating at STARVE_LIMIT, cleared on grant or req_valid=0.
REQ-031 With AXI_RD_ARB_STARVE_EN: any counter at STARVE_LIMIT overrides round-robin; the lowest-index starving requester wins; rr_ptr updates per REQ-023.
REQ-032 Without AXI_RD_ARB_STARVE_EN: counters are absent and arbitration is pure round-robin.

Verification
REQ-033 Reset, then req_valid=4'b0001, addr0=0x100, user_req_ready=1 -> user_req_valid=1 one cycle later, addr=0x100, id=0, grant_idx=0.
REQ-034 req_valid=4'b1111 held, user_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one-hot req_ready each cycle.
REQ-035 Held request to requester 2, user_req_ready=0 for 5 cycles -> payload stable 5 cycles, req_ready=0, then handshake.
REQ-036 rr_ptr=3, req_valid=4'b1001 -> winner 3, next winner 0 (wrap).
REQ-037 AXI_RD_ARB_STARVE_EN, STARVE_LIMIT=3, user_req_ready=0 for 4 cycles with requester 1 waiting -> after release requester 1 wins over round-robin choice.
REQ-038 rst_n=0 for one cycle while HOLD -> user_req_valid=0 next cycle, rr_ptr=0, next grant from requester 0.
